// File: rtl/glitch_wb.sv
// Wishbone-slave clock glitch generator: entries (mode, width, delay) are staged
// through byte registers, queued in a FIFO and replayed on clk_out by the engine.
module glitch_wb #(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] dat_i,
  input  logic [5:2] adr_i,
  output logic [7:0] dat_o,
  input  logic       stb_i,
  input  logic       we_i,
  output logic       ack_o,
  input  logic       clk_in,
  input  logic       clk_gl,
  output logic       clk_out
);

  localparam int AW = $clog2(QUEUE_DEPTH);

  localparam logic [3:0] ADR_STATUS = 4'h0;
  localparam logic [3:0] ADR_MODE   = 4'h1;
  localparam logic [3:0] ADR_WIDTH  = 4'h2;
  localparam logic [3:0] ADR_DLY_LO = 4'h3;
  localparam logic [3:0] ADR_DLY_HI = 4'h4;

  localparam logic [7:0] MODE_ZERO  = 8'h01;
  localparam logic [7:0] MODE_ONE   = 8'h02;
  localparam logic [7:0] MODE_NOT   = 8'h04;
  localparam logic [7:0] MODE_CLKGL = 8'h08;

  typedef enum logic [1:0] {IDLE, READ, DELAY, WIDTH} state_t;

  state_t      state_q;
  logic [7:0]  mode_q, width_q, dly_lo_q, dly_hi_q;
  logic [7:0]  cur_mode_q, wcnt_q;
  logic [15:0] dcnt_q;
  logic        ack_q;
  logic [7:0]  dat_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [31:0] fifo_mem [QUEUE_DEPTH];

  logic        fifo_empty, fifo_full;
  logic        wr_en, push, pop, start;
  logic [31:0] head;
  logic [7:0]  head_mode, head_width;
  logic [15:0] head_delay;
  logic [7:0]  rdata_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_en = stb_i && we_i;
  assign push  = wr_en && (adr_i == ADR_DLY_HI) && !fifo_full;
  assign start = wr_en && (adr_i == ADR_STATUS) && dat_i[0] && (state_q == IDLE);
  assign pop   = (state_q == READ) && !fifo_empty;

  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_mode  = head[31:24];
  assign head_width = head[23:16];
  assign head_delay = head[15:0];

  always_comb begin
    rdata_d = 8'h00;
    case (adr_i)
      ADR_STATUS: rdata_d = {7'd0, state_q == IDLE};
      ADR_MODE:   rdata_d = mode_q;
      ADR_WIDTH:  rdata_d = width_q;
      ADR_DLY_LO: rdata_d = dly_lo_q;
      ADR_DLY_HI: rdata_d = dly_hi_q;
      default:    rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      mode_q   <= 8'h00;
      width_q  <= 8'h00;
      dly_lo_q <= 8'h00;
      dly_hi_q <= 8'h00;
    end else begin
      ack_q <= stb_i;
      if (stb_i) dat_q <= rdata_d;
      if (wr_en) begin
        case (adr_i)
          ADR_MODE:   mode_q   <= dat_i;
          ADR_WIDTH:  width_q  <= dat_i;
          ADR_DLY_LO: dly_lo_q <= dat_i;
          ADR_DLY_HI: dly_hi_q <= dat_i;
          default:    ;
        endcase
      end
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

  // The delay high byte comes straight from the bus so the push uses this write's value.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {mode_q, width_q, dat_i, dly_lo_q};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cur_mode_q <= 8'h00;
      dcnt_q     <= 16'd0;
      wcnt_q     <= 8'd0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= READ;
        READ: begin
          if (fifo_empty) begin
            state_q <= IDLE;
          end else begin
            cur_mode_q <= head_mode;
            dcnt_q     <= head_delay;
            wcnt_q     <= head_width;
            if (head_delay != 16'd0)     state_q <= DELAY;
            else if (head_width != 8'd0) state_q <= WIDTH;
            else                         state_q <= READ;
          end
        end
        // Counters are loaded with the full length and leave on reaching one.
        DELAY: begin
          if (dcnt_q == 16'd1) state_q <= (wcnt_q != 8'd0) ? WIDTH : READ;
          else                 dcnt_q  <= dcnt_q - 16'd1;
        end
        WIDTH: begin
          if (wcnt_q == 8'd1) state_q <= READ;
          else                wcnt_q  <= wcnt_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    clk_out = clk_in;
    if (state_q == WIDTH) begin
      case (cur_mode_q)
        MODE_ZERO:  clk_out = 1'b0;
        MODE_ONE:   clk_out = 1'b1;
        MODE_NOT:   clk_out = ~clk_in;
        MODE_CLKGL: clk_out = clk_gl;
        default:    clk_out = clk_in;
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_wb.sv
// Bench for glitch_wb: directed register tests plus randomized glitch queues,
// checked cycle by cycle against a schedule built from the queued entries.
`timescale 1ns/1ps
module tb_glitch_wb;

  localparam int QD = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic [3:0] adr_i = 4'h0;
  logic [7:0] dat_o;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic       ack_o;
  logic       clk_in = 1'b0;
  logic       clk_gl = 1'b0;
  logic       clk_out;

  int cmp_count = 0;
  int err_count = 0;

  typedef struct {
    int mode;
    int width;
    int delay;
  } entry_t;

  entry_t model_q[$];

  glitch_wb #(.QUEUE_DEPTH(QD)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .dat_i  (dat_i),
    .adr_i  (adr_i),
    .dat_o  (dat_o),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .ack_o  (ack_o),
    .clk_in (clk_in),
    .clk_gl (clk_gl),
    .clk_out(clk_out)
  );

  // Half-integer toggle times keep clk_in/clk_gl edges away from integer sample points.
  always #10 clk_i = ~clk_i;
  initial begin
    #3.5;
    forever #7 clk_in = ~clk_in;
  end
  initial begin
    #1.5;
    forever #3 clk_gl = ~clk_gl;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_clk(input int m, input logic ci, input logic cg);
    if (m < 0) return ci;
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      4:       return ~ci;
      8:       return cg;
      default: return ci;
    endcase
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_i);
    adr_i = a; dat_i = d; we_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i); #1;
    stb_i = 1'b0; we_i = 1'b0;
    $display("wr adr=%0h dat=%02h", a, d);
    check("wr_ack", {15'd0, ack_o}, 16'd1);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk_i);
    adr_i = a; we_i = 1'b0; stb_i = 1'b1;
    @(posedge clk_i); #1;
    stb_i = 1'b0;
    $display("rd adr=%0h dat=%02h", a, dat_o);
    check("rd_ack", {15'd0, ack_o}, 16'd1);
    check(tag, {8'd0, dat_o}, {8'd0, exp});
    @(posedge clk_i); #1;
    check("ack_drop", {15'd0, ack_o}, 16'd0);
  endtask

  task automatic push_entry(input int m, input int w, input int d);
    entry_t e;
    bus_write(4'h1, m[7:0]);
    bus_write(4'h2, w[7:0]);
    bus_write(4'h3, d[7:0]);
    bus_write(4'h4, d[15:8]);
    e.mode = m; e.width = w; e.delay = d;
    if (model_q.size() < QD) model_q.push_back(e);
  endtask

  // Each entry costs one fetch cycle, then delay plain cycles, then width glitched
  // cycles; one more fetch finds the queue empty before returning to ready.
  task automatic run_and_check(input string tag);
    int sched[$];
    foreach (model_q[k]) begin
      sched.push_back(-1);
      repeat (model_q[k].delay) sched.push_back(-1);
      repeat (model_q[k].width) sched.push_back(model_q[k].mode);
    end
    sched.push_back(-1);
    model_q.delete();
    bus_write(4'h0, 8'h01);
    for (int i = 0; i < sched.size(); i++) begin
      if (i == 0 && sched.size() > 1) begin
        adr_i = 4'h0; we_i = 1'b0; stb_i = 1'b1;
      end
      if (i == 1) begin
        stb_i = 1'b0;
        check("busy_ack", {15'd0, ack_o}, 16'd1);
        check("busy_status", {8'd0, dat_o}, 16'd0);
      end
      check(tag, {15'd0, clk_out}, {15'd0, exp_clk(sched[i], clk_in, clk_gl)});
      #10;
      check(tag, {15'd0, clk_out}, {15'd0, exp_clk(sched[i], clk_in, clk_gl)});
      @(posedge clk_i); #1;
    end
    repeat (2) begin
      check("idle_clk", {15'd0, clk_out}, {15'd0, clk_in});
      #10;
      check("idle_clk", {15'd0, clk_out}, {15'd0, clk_in});
      @(posedge clk_i); #1;
    end
    bus_read(4'h0, 8'h01, "status_done");
    $display("run %s: %0d cycles", tag, sched.size());
  endtask

  initial begin
    int modes [7] = '{0, 1, 2, 4, 8, 16, 3};
    int n;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", {15'd0, ack_o}, 16'd0);
    check("rst_dat", {8'd0, dat_o}, 16'd0);
    check("rst_clk", {15'd0, clk_out}, {15'd0, clk_in});
    @(negedge clk_i);
    rst_i = 1'b1;

    bus_read(4'h0, 8'h01, "status_reset");
    for (int a = 1; a <= 4; a++) bus_read(a[3:0], 8'h00, "queue_reset");
    bus_write(4'h9, 8'h5a);
    bus_read(4'h9, 8'h00, "unmapped");

    push_entry(4, 8'h12, 3);
    bus_read(4'h1, 8'h04, "rb_mode");
    bus_read(4'h2, 8'h12, "rb_width");
    bus_read(4'h3, 8'h03, "rb_dly_lo");
    bus_read(4'h4, 8'h00, "rb_dly_hi");
    run_and_check("not_window");

    push_entry(8, 2, 2);
    push_entry(8, 3, 0);
    run_and_check("clkgl_pair");

    push_entry(1, 0, 3);
    push_entry(1, 0, 0);
    run_and_check("zero_width");

    for (int k = 0; k < QD + 1; k++) push_entry(2, k + 1, 0);
    run_and_check("overflow");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, QD + 2);
      for (int k = 0; k < n; k++)
        push_entry(modes[$urandom_range(0, 6)], $urandom_range(0, 4), $urandom_range(0, 4));
      run_and_check("random");
    end

    for (int k = 0; k < 3; k++) push_entry(1, 6, 2);
    bus_write(4'h0, 8'h01);
    model_q.delete();
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("abort_clk", {15'd0, clk_out}, {15'd0, clk_in});
    @(negedge clk_i);
    rst_i = 1'b1;
    bus_read(4'h0, 8'h01, "abort_status");
    bus_read(4'h1, 8'h00, "abort_staging");
    run_and_check("abort_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/glitch_wb.md
Name: glitch_wb

Overview:
glitch_wb is a Wishbone-slave clock glitch generator. A host loads glitch entries (mode, width, delay) through 8-bit registers into an internal FIFO. A start command then makes an internal engine play the entries back in order on clk_out. Outside a glitch window, clk_out passes clk_in through; inside a window, the selected mode replaces it.

Parameters:
QUEUE_DEPTH, 8, number of glitch entries held in the FIFO (power of two).

Ports:
clk_i  in  1  system/bus clock; all state advances on its rising edge
rst_i  in  1  synchronous, active-low reset
dat_i  in  8  Wishbone write data
adr_i  in  4 ([5:2])  register select
dat_o  out 8  Wishbone read data (registered)
stb_i  in  1  Wishbone strobe
we_i   in  1  Wishbone write enable
ack_o  out 1  Wishbone acknowledge (registered)
clk_in in  1  clock to be passed through or glitched
clk_gl in  1  alternate fast clock, used in CLKGL mode
clk_out out 1  glitched output clock (combinational mux)

Behaviour:
Register map (adr_i):
- 0x0 STATUS. Read: bit0 = ready, other bits 0. Write: dat_i[0]=1 starts the engine.
- 0x1 QUEUE_0 = mode (R/W).
- 0x2 QUEUE_1 = width[7:0] (R/W).
- 0x3 QUEUE_2 = delay[7:0] (R/W).
- 0x4 QUEUE_3 = delay[15:8] (R/W). A write here also pushes entry {mode, width, delay} into the FIFO.
- Any other address: reads 0x00, writes ignored, ack still given.

Mode encodings:
- BYPASS = 0x00
- ZERO = 0x01
- ONE = 0x02
- NOT = 0x04
- CLKGL = 0x08
- Any other value behaves as BYPASS.

Bus handshake:
- Each clk_i edge with stb_i=1 is one access.
- ack_o goes to 1 on the following edge for exactly one cycle. dat_o is updated on that same edge.
- Writes take effect on the edge that samples stb_i.
- Staging registers keep their value after a push, so reads return the last written value.

Reset (rst_i=0 at a clock edge):
- ack_o=0, dat_o=0x00.
- Staging registers = 0; FIFO empty; state = IDLE.
- clk_out follows clk_in (BYPASS).
- Reset mid-run aborts the run immediately and empties the FIFO.

Engine states: IDLE, READ, DELAY, WIDTH.
- ready = (state == IDLE).
- IDLE: a START write moves to READ on the write-sampling edge, so the next status read returns 0x00. START while not IDLE is ignored. A status write with dat_i[0]=0 is ignored.
- READ (1 cycle): if the FIFO is empty, go to IDLE. Otherwise pop an entry and load mode, delay counter and width counter. Next state is DELAY if delay>0, else WIDTH if width>0, else READ.
- DELAY: lasts exactly `delay` clk_i cycles. Then go to WIDTH if width>0, else READ.
- WIDTH: lasts exactly `width` clk_i cycles. Then go to READ.
- Result: the engine runs every queued entry back-to-back, then returns to IDLE.
- A push while running is accepted and will be executed in the same run.
- A push while the FIFO is full is dropped; the stored entries are unchanged.
- Simultaneous push and pop in one cycle are both performed.

clk_out:
- In WIDTH state: ZERO gives 0; ONE gives 1; NOT gives ~clk_in; CLKGL gives clk_gl; BYPASS gives clk_in.
- All other states: clk_in.

Test Plan:
- After reset, read STATUS -> 0x01. Read QUEUE_0..3 -> 0x00. ack_o pulses one cycle after each stb_i.
- Write QUEUE_0=0x04, QUEUE_1=0x12, QUEUE_2=0x03, QUEUE_3=0x00, then read each back -> 0x04, 0x12, 0x03, 0x00. One entry is queued.
- Write STATUS=0x01, then read STATUS -> 0x00. After 1000 ns (50 clk_i cycles) STATUS -> 0x01. clk_out = ~clk_in for exactly 18 clk_i cycles, starting after a 3-cycle delay.
- Mode 0x08; queue (width 2, delay 2) then (width 3, delay 0); start -> STATUS 0x00. clk_out = clk_gl for 2 cycles after a 2-cycle delay, then clk_gl for 3 cycles. Back to IDLE within 12 cycles.
- Queue (width 0, delay 3) and (width 0, delay 0); start -> no glitch window at all (clk_out == clk_in throughout). Returns to ready.
- Queue QUEUE_DEPTH+1 entries -> only QUEUE_DEPTH are executed. Assert rst_i=0 mid-run -> STATUS 0x01 and FIFO empty.
